// File: rtl/mem_port_arbiter.sv
// Arbitrates an instruction-fetch port and a load/store port onto one shared memory port.
// Data is favoured, with a bounded streak, and every transaction ends in an ack or a timeout.
module mem_port_arbiter #(
    parameter int XLEN            = 32,
    parameter int MAX_DATA_STREAK = 4,
    parameter int TIMEOUT         = 255
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_instr_req,
    input  logic [XLEN-1:0] i_instr_addr,
    output logic [XLEN-1:0] o_instr_data,
    output logic            o_instr_ack,
    input  logic            i_data_req,
    input  logic [XLEN-1:0] i_data_addr,
    input  logic [XLEN-1:0] i_data_wr_data,
    input  logic [1:0]      i_data_mask,
    input  logic            i_data_wr_en,
    output logic [XLEN-1:0] o_data_rd_data,
    output logic            o_data_ack,
    output logic            o_mem_req,
    output logic [XLEN-1:0] o_mem_addr,
    output logic [XLEN-1:0] o_mem_wr_data,
    output logic [1:0]      o_mem_mask,
    output logic            o_mem_wr_en,
    input  logic [XLEN-1:0] i_mem_rd_data,
    input  logic            i_mem_ack,
    output logic            o_timeout
);

    localparam int             SW         = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [SW-1:0]  STREAK_MAX = SW'(MAX_DATA_STREAK);
    localparam logic [7:0]     WAIT_MAX   = 8'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;

    state_t          state_q;
    logic [XLEN-1:0] instr_data_q, data_rd_data_q;
    logic            instr_ack_q, data_ack_q, timeout_q;
    logic            mem_req_q, mem_wr_en_q;
    logic [XLEN-1:0] mem_addr_q, mem_wr_data_q;
    logic [1:0]      mem_mask_q;
    logic [SW-1:0]   streak_q;
    logic [7:0]      wait_q;

    logic            pick_data, pick_instr;
    logic [7:0]      wait_d;
    logic            timeout_hit;

    // Data wins a conflict until it has taken MAX_DATA_STREAK grants in a row.
    always_comb begin
        pick_data  = 1'b0;
        pick_instr = 1'b0;
        if (i_data_req && (!i_instr_req || streak_q != STREAK_MAX)) begin
            pick_data = 1'b1;
        end else if (i_instr_req) begin
            pick_instr = 1'b1;
        end
    end

    assign wait_d      = wait_q + 8'd1;
    assign timeout_hit = (wait_d == WAIT_MAX);

    // NOTE: every register, including the returned-data holding registers, is reset so the
    // async reset can kill an in-flight transaction without leaving stale outputs behind.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q        <= IDLE;
            instr_data_q   <= '0;
            data_rd_data_q <= '0;
            instr_ack_q    <= 1'b0;
            data_ack_q     <= 1'b0;
            timeout_q      <= 1'b0;
            mem_req_q      <= 1'b0;
            mem_addr_q     <= '0;
            mem_wr_data_q  <= '0;
            mem_mask_q     <= 2'b00;
            mem_wr_en_q    <= 1'b0;
            streak_q       <= '0;
            wait_q         <= 8'd0;
        end else begin
            instr_ack_q <= 1'b0;
            data_ack_q  <= 1'b0;
            timeout_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_data) begin
                        state_q       <= GRANT_D;
                        mem_req_q     <= 1'b1;
                        mem_addr_q    <= i_data_addr;
                        mem_wr_data_q <= i_data_wr_data;
                        mem_mask_q    <= i_data_mask;
                        mem_wr_en_q   <= i_data_wr_en;
                        wait_q        <= 8'd0;
                        if (!i_instr_req) begin
                            streak_q <= '0;
                        end else if (streak_q != STREAK_MAX) begin
                            streak_q <= streak_q + 1'b1;
                        end
                    end else if (pick_instr) begin
                        state_q       <= GRANT_I;
                        mem_req_q     <= 1'b1;
                        mem_addr_q    <= i_instr_addr;
                        mem_wr_data_q <= '0;
                        mem_mask_q    <= 2'b10;
                        mem_wr_en_q   <= 1'b0;
                        wait_q        <= 8'd0;
                        streak_q      <= '0;
                    end
                end
                GRANT_I, GRANT_D: begin
                    // A real ack on the final wait cycle takes priority over the timeout.
                    if (i_mem_ack || timeout_hit) begin
                        state_q   <= IDLE;
                        mem_req_q <= 1'b0;
                        timeout_q <= !i_mem_ack;
                        if (state_q == GRANT_I) begin
                            instr_ack_q <= 1'b1;
                            if (i_mem_ack) instr_data_q <= i_mem_rd_data;
                        end else begin
                            data_ack_q <= 1'b1;
                            if (i_mem_ack) data_rd_data_q <= i_mem_rd_data;
                        end
                    end else begin
                        wait_q <= wait_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_instr_data   = instr_data_q;
    assign o_instr_ack    = instr_ack_q;
    assign o_data_rd_data = data_rd_data_q;
    assign o_data_ack     = data_ack_q;
    assign o_mem_req      = mem_req_q;
    assign o_mem_addr     = mem_addr_q;
    assign o_mem_wr_data  = mem_wr_data_q;
    assign o_mem_mask     = mem_mask_q;
    assign o_mem_wr_en    = mem_wr_en_q;
    assign o_timeout      = timeout_q;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width.
REQ-002 SHALL have parameter MAX_DATA_STREAK, default 4, consecutive data grants allowed while instr pending.
REQ-003 SHALL have parameter TIMEOUT, default 255, max wait cycles for i_mem_ack (8-bit counter).
REQ-004 SHALL use one clock; reset is asynchronous and active-high; ports: i_clk input 1 clock; i_rst input 1 async active-high reset.
REQ-005 SHALL have i_instr_req in 1 fetch request; i_instr_addr in XLEN fetch address.
REQ-006 SHALL have o_instr_data out XLEN fetch data; o_instr_ack out 1 fetch done pulse.
REQ-007 SHALL have i_data_req in 1; i_data_addr in XLEN; i_data_wr_data in XLEN; i_data_mask in 2 size code; i_data_wr_en in 1.
REQ-008 SHALL have o_data_rd_data out XLEN load data; o_data_ack out 1 data done pulse.
REQ-009 SHALL have o_mem_req out 1; o_mem_addr out XLEN; o_mem_wr_data out XLEN; o_mem_mask out 2; o_mem_wr_en out 1.
REQ-010 SHALL have i_mem_rd_data in XLEN; i_mem_ack in 1 shared-port completion.
REQ-011 SHALL have o_timeout out 1 one-cycle pulse on abandoned transaction.

Function
REQ-012 SHALL implement FSM states IDLE, GRANT_I, GRANT_D; IDLE on reset.
REQ-013 IDLE: requests sampled each cycle; none -> stay IDLE, o_mem_req 0.
REQ-014 IDLE, only one request -> that requester granted; both -> data granted unless streak counter == MAX_DATA_STREAK, then instr granted.
REQ-015 On grant at edge N: request fields latched into internal registers; o_mem_req=1 from cycle N+1; o_mem_* driven only from latched registers, stable until completion.
REQ-016 GRANT_I: o_mem_wr_en=0, o_mem_mask=2'b10 (word), o_mem_wr_data=0.
REQ-017 GRANT_x, i_mem_ack=1 at edge M: i_mem_rd_data registered into o_x_rd_data, o_x_ack=1 during cycle M+1 only, o_mem_req=0 from M+1, state -> IDLE.
REQ-018 Minimum turnaround: request sampled N, ack M>=N+1, completion pulse M+1, next grant earliest at edge M+1 (o_mem_req again from M+2).
REQ-019 o_instr_data/o_data_rd_data SHALL hold last value between acks; write transactions update o_data_rd_data with i_mem_rd_data as returned.
REQ-020 Streak counter: increments on each data grant while i_instr_req=1 at grant, saturates at MAX_DATA_STREAK; cleared on any instr grant or data grant with i_instr_req=0.
REQ-021 Wait counter: cleared on grant, increments each GRANT cycle without i_mem_ack; at TIMEOUT -> o_timeout=1 and o_x_ack=1 for one cycle, o_x_rd_data unchanged, o_mem_req=0, state -> IDLE.
REQ-022 i_mem_ack and timeout reached same edge -> ack wins, o_timeout stays 0.
REQ-023 Requester dropping req while granted SHALL NOT abort; transaction completes, ack still pulsed.
REQ-024 i_mem_ack in IDLE SHALL be ignored (no ack pulse, no data update).
REQ-025 Requester holding req through its ack cycle SHALL be treated as a new request in the following IDLE cycle.
REQ-026 o_instr_ack and o_data_ack SHALL never be 1 in the same cycle.

Reset
REQ-027 i_rst=1 SHALL immediately force: state IDLE, o_mem_req 0, o_mem_addr/wr_data 0, o_mem_mask 0, o_mem_wr_en 0, o_instr_ack/o_data_ack 0, o_instr_data/o_data_rd_data 0, o_timeout 0, counters 0.
REQ-028 Reset mid-transaction SHALL discard it with no ack pulse; i_mem_ack arriving after reset release in IDLE is ignored.

Verification
REQ-029 Single fetch: i_instr_req=1, addr 0x100; mem ack 2 cycles after o_mem_req with data 0x00000013 -> o_mem_addr 0x100, wr_en 0, o_instr_ack 1 cycle, o_instr_data 0x13.
REQ-030 Conflict: both req every cycle, mem acks after 1 cycle -> grant order D,D,D,D,I,D,D,D,D,I (MAX_DATA_STREAK=4).
REQ-031 Store: data req addr 0x2000, wr_data 0xDEADBEEF, mask 2, wr_en 1 -> o_mem_* match for whole wait, o_data_ack single pulse.
REQ-032 Timeout: grant data, withhold ack -> o_timeout and o_data_ack pulse exactly 255 cycles after grant, o_data_rd_data unchanged, next grant follows.
REQ-033 Async reset: assert i_rst mid GRANT_I between edges -> o_mem_req 0 same cycle; post-release stray i_mem_ack produces no ack.
REQ-034 Ack/timeout collision: ack on 255th wait cycle with data 0x55 -> o_data_ack, o_data_rd_data 0x55, o_timeout 0.
